// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: an operation request
// channel (in_valid/in_ready) and a result channel (out_valid/out_ready).
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             DivZero;

  // Requester / result consumer side
  modport master (
    output in_valid, ALUControl, A, B, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, DivZero
  );

  // ALU side
  modport slave (
    input  in_valid, ALUControl, A, B, out_ready,
    output in_ready, out_valid, ALUResult, Zero, DivZero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU. Simple ops and degenerate divides finish
// one edge after acceptance; multiply/divide iterate WIDTH cycles on operand
// magnitudes (shift-add / restoring shift-subtract) and apply the sign at the
// last step. Results are held until the consumer takes them.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  // WIDTH is a power of two, so the final iteration index is all ones
  localparam logic [SHW-1:0] LAST_CNT = {SHW{1'b1}};

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               divz_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   mag_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;   // {hi, lo} product or {remainder, quotient}
  logic [SHW-1:0]     cnt_q;
  logic               neg_q;   // result needs negating at the final step

  // Acceptance-time decode
  logic               is_md, is_div, sgn, a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               start_md, imm_divz, init_neg;
  logic [WIDTH-1:0]   imm_res, init_mag;
  logic [2*WIDTH-1:0] init_acc;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_bit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, md_res;

  function automatic logic [WIDTH-1:0] alu_basic(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] r;
    sh = b[SHW-1:0];
    r  = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode the incoming request: immediate result or iterative start values
  always_comb begin
    is_md    = bus.ALUControl[3] & (bus.ALUControl[2] | bus.ALUControl[1]);
    is_div   = bus.ALUControl[3] & bus.ALUControl[2];
    // MUL/MULH and DIV/REM are signed; DIVU/REMU are not
    sgn      = ~is_div | ~bus.ALUControl[0];
    a_neg    = sgn & bus.A[WIDTH-1];
    b_neg    = sgn & bus.B[WIDTH-1];
    a_mag    = a_neg ? -bus.A : bus.A;
    b_mag    = b_neg ? -bus.B : bus.B;
    b_zero   = (bus.B == '0);
    ovf      = is_div & ~bus.ALUControl[0] & (bus.A == MOST_NEG) & (bus.B == '1);
    init_acc = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
    init_mag = is_div ? b_mag : a_mag;
    // remainder follows the dividend; quotient/product follow the sign product
    init_neg = (is_div & bus.ALUControl[1]) ? a_neg : (a_neg ^ b_neg);
    start_md = 1'b0;
    imm_divz = 1'b0;
    imm_res  = alu_basic(bus.ALUControl, bus.A, bus.B);
    if (is_md) begin
      imm_res = '0;
      if (!MD_EN) begin
        imm_res = '0;
      end else if (is_div && b_zero) begin
        imm_res  = bus.ALUControl[1] ? bus.A : '1;
        imm_divz = 1'b1;
      end else if (ovf) begin
        imm_res = bus.ALUControl[1] ? '0 : bus.A;
      end else begin
        start_md = 1'b1;
      end
    end
  end

  // One multiply or divide step, plus sign fix-up of the step's outcome
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_bit   = (div_shift >= {1'b0, mag_q});
    div_rem   = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_bit};
    acc_d     = op_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? -acc_d : acc_d;
    quo_s     = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem_s     = neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:  md_res = prod_s[WIDTH-1:0];
      OP_MULH: md_res = prod_s[2*WIDTH-1:WIDTH];
      default: md_res = op_q[1] ? rem_s : quo_s;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      divz_q      <= 1'b0;
      op_q        <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q       <= bus.ALUControl;
            in_ready_q <= 1'b0;
            if (start_md) begin
              state_q <= CALC;
              acc_q   <= init_acc;
              mag_q   <= init_mag;
              neg_q   <= init_neg;
              cnt_q   <= '0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= imm_res;
              zero_q      <= (imm_res == '0);
              divz_q      <= imm_divz;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= md_res;
            zero_q      <= (md_res == '0);
            divz_q      <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.DivZero   = divz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: one instance with multiply/divide enabled and
// one without. Expected results come from a behavioural model using native
// wide arithmetic and are queued at acceptance, popped on out_valid.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus0 ();
  alu_mc_if #(.WIDTH(32)) bus1 ();

  alu_mc #(.WIDTH(32), .MD_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  alu_mc #(.WIDTH(32), .MD_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        divz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit md_en);
    exp_t        e;
    int          sa, sb;
    longint      pp;
    logic [63:0] pu;
    sa = a; sb = b;
    e.res = '0; e.divz = 1'b0; e.lat = 1;
    case (op)
      4'h0: e.res = a + b;
      4'h1: e.res = a - b;
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = a >> b[4:0];
      4'h6: e.res = sa >>> b[4:0];
      4'h7: e.res = a << b[4:0];
      4'h8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: e.res = (a < b) ? 32'd1 : 32'd0;
      4'hA, 4'hB: begin
        pp = longint'(sa) * longint'(sb);
        pu = pp;
        e.res = op[0] ? pu[63:32] : pu[31:0];
        e.lat = 33;
      end
      4'hC: begin
        if (b == 0) begin e.res = '1; e.divz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
        else begin e.res = sa / sb; e.lat = 33; end
      end
      4'hD: begin
        if (b == 0) begin e.res = '1; e.divz = 1'b1; end
        else begin e.res = a / b; e.lat = 33; end
      end
      4'hE: begin
        if (b == 0) begin e.res = a; e.divz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = '0;
        else begin e.res = sa % sb; e.lat = 33; end
      end
      default: begin
        if (b == 0) begin e.res = a; e.divz = 1'b1; end
        else begin e.res = a % b; e.lat = 33; end
      end
    endcase
    if (!md_en && op >= 4'hA) begin
      e.res = '0; e.divz = 1'b0; e.lat = 1;
    end
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus1.in_valid = v; bus1.ALUControl = op; bus1.A = a; bus1.B = b;
    end else begin
      bus0.in_valid = v; bus0.ALUControl = op; bus0.A = a; bus0.B = b;
    end
  endtask

  task automatic set_ordy(input bit sel, input logic v);
    if (sel) bus1.out_ready = v;
    else     bus0.out_ready = v;
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus1.in_ready : bus0.in_ready;
  endfunction
  function automatic logic ovld(input bit sel);
    return sel ? bus1.out_valid : bus0.out_valid;
  endfunction
  function automatic logic [31:0] rslt(input bit sel);
    return sel ? bus1.ALUResult : bus0.ALUResult;
  endfunction
  function automatic logic zf(input bit sel);
    return sel ? bus1.Zero : bus0.Zero;
  endfunction
  function automatic logic dzf(input bit sel);
    return sel ? bus1.DivZero : bus0.DivZero;
  endfunction

  // Issue one op, check latency/result/flags, optionally stall the consumer
  task automatic do_op(input bit sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t        g;
    int          n, lat;
    logic [31:0] held;
    @(negedge clk);
    n = 0;
    while (!rdy(sel) && n < 100) begin @(negedge clk); n++; end
    if (!rdy(sel)) begin
      check("in_ready_timeout", 64'(rdy(sel)), 64'd1);
      return;
    end
    drive(sel, 1'b1, op, a, b);
    @(posedge clk);
    sb_q.push_back(model(op, a, b, !sel));
    #1;
    drive(sel, 1'b0, 4'($urandom), $urandom, $urandom);
    lat = 1;
    while (!ovld(sel) && lat < 100) begin @(posedge clk); #1; lat++; end
    g = sb_q.pop_front();
    check("latency", 64'(lat), 64'(g.lat));
    check("result", 64'(rslt(sel)), 64'(g.res));
    check("zero", 64'(zf(sel)), 64'(g.zero));
    check("divzero", 64'(dzf(sel)), 64'(g.divz));
    check("busy_in_ready", 64'(rdy(sel)), 64'd0);
    held = rslt(sel);
    for (int i = 0; i < hold; i++) begin
      drive(sel, 1'b1, 4'h0, 32'd1, 32'd1);
      @(posedge clk); #1;
      check("hold_valid", 64'(ovld(sel)), 64'd1);
      check("hold_result", 64'(rslt(sel)), 64'(held));
      check("hold_in_ready", 64'(rdy(sel)), 64'd0);
    end
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    drive(sel, 1'b0, 4'h0, 32'd0, 32'd0);
    check("release_valid", 64'(ovld(sel)), 64'd0);
    check("release_in_ready", 64'(rdy(sel)), 64'd1);
    if (hold > 0) begin
      @(posedge clk); #1;
      check("no_spurious_accept", 64'(ovld(sel)), 64'd0);
      check("idle_in_ready", 64'(rdy(sel)), 64'd1);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(bus0.out_valid), 64'd0);
    check("reset_result", 64'(bus0.ALUResult), 64'd0);
    check("reset_zero", 64'(bus0.Zero), 64'd0);
    check("reset_divzero", 64'(bus0.DivZero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(bus0.in_ready), 64'd1);

    // Simple ops
    do_op(1'b0, 4'h0, 32'd5, 32'd7, 0);
    do_op(1'b0, 4'h1, 32'd9, 32'd9, 0);
    do_op(1'b0, 4'h6, 32'h8000_0000, 32'h24, 0);
    do_op(1'b0, 4'h7, 32'd1, 32'd31, 0);
    do_op(1'b0, 4'h5, 32'hF000_000F, 32'hFFFF_FFE4, 0);
    do_op(1'b0, 4'h9, 32'd1, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'h8, 32'd1, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'h8, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1'b0, 4'h4, 32'hA5A5_A5A5, 32'hFFFF_0000, 0);

    // Multiply
    do_op(1'b0, 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'hB, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(1'b0, 4'hA, 32'd123456, 32'hFFFF_FF85, 0);

    // Divide, including zero divisor and signed overflow
    do_op(1'b0, 4'hC, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b0, 4'hE, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b0, 4'hD, 32'd100, 32'd0, 0);
    do_op(1'b0, 4'hF, 32'd100, 32'd0, 0);
    do_op(1'b0, 4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 4'hD, 32'hFFFF_FFFF, 32'd7, 0);
    do_op(1'b0, 4'hE, 32'd7, 32'hFFFF_FFFE, 0);

    // Consumer backpressure with a concurrent request
    do_op(1'b0, 4'h0, 32'd40, 32'd2, 5);
    do_op(1'b0, 4'hC, 32'd1000, 32'hFFFF_FFF9, 5);

    // Random mix
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_op(1'b0, rop, ra, rb, 0);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    drive(1'b0, 1'b1, 4'hC, 32'd1000, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #2;
    check("mid_div_busy", 64'(bus0.out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus0.out_valid), 64'd0);
    check("async_rst_result", 64'(bus0.ALUResult), 64'd0);
    check("async_rst_zero", 64'(bus0.Zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check("discarded_op_valid", 64'(bus0.out_valid), 64'd0);
    do_op(1'b0, 4'h0, 32'd3, 32'd4, 0);

    // Instance without multiply/divide
    do_op(1'b1, 4'hA, 32'd6, 32'd7, 0);
    do_op(1'b1, 4'hD, 32'd100, 32'd0, 0);
    do_op(1'b1, 4'h0, 32'd3, 32'd4, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
